// File: rtl/sa_tile_ctrl.sv
// Sequencer for one systolic-array tile: clear accumulators, stream k_len operands,
// flush the wavefront through the array, then hand out result rows under backpressure.
module sa_tile_ctrl #(
    parameter  int ROWS  = 4,
    parameter  int COLS  = 4,
    parameter  int K_MAX = 64,
    localparam int KW    = $clog2(K_MAX + 1),
    localparam int AW    = $clog2(K_MAX),
    localparam int RW    = $clog2(ROWS),
    localparam int FLUSH = ROWS + COLS - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          pe_en,
    output logic          pe_clr,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_row
);

    localparam int FW = $clog2(FLUSH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] klen_q, klen_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          err_q, err_d;
    logic          k_ok;

    assign k_ok = (k_len != '0) && (k_len <= KW'(K_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            klen_q  <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        row_d   = row_q;
        err_d   = 1'b0;

        // Abort abandons the tile from any active state; counters restart clean.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            fcnt_d  = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (k_ok) begin
                            state_d = S_CLEAR;
                            klen_d  = k_len;
                            cnt_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                end
                S_FEED: begin
                    if (cnt_q == (klen_q - KW'(1))) begin
                        state_d = S_FLUSH;
                        cnt_d   = '0;
                        fcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + KW'(1);
                    end
                end
                S_FLUSH: begin
                    // Last operand needs ROWS+COLS-1 steps to reach the far corner PE.
                    if (fcnt_q == FW'(FLUSH - 1)) begin
                        state_d = S_DRAIN;
                        fcnt_d  = '0;
                        row_d   = '0;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
                S_DRAIN: begin
                    if (res_ready) begin
                        if (row_q == RW'(ROWS - 1)) begin
                            state_d = S_DONE;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign pe_clr    = (state_q == S_CLEAR);
    assign pe_en     = (state_q == S_FEED) || (state_q == S_FLUSH);
    assign rd_valid  = (state_q == S_FEED);
    assign rd_addr   = rd_valid ? cnt_q[AW-1:0] : '0;
    assign res_valid = (state_q == S_DRAIN);
    assign res_row   = res_valid ? row_q : '0;

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Bench for sa_tile_ctrl: tile schedules predicted from cycle arithmetic and a count of
// accepted result rows, with random backpressure, random ignored starts and fault cases.
module tb_sa_tile_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int K_MAX = 64;
    localparam int FLUSH = ROWS + COLS - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] k_len;
    logic       abort;
    logic       busy, done, err, pe_en, pe_clr, rd_valid, res_valid;
    logic [5:0] rd_addr;
    logic       res_ready;
    logic [1:0] res_row;

    int checks   = 0;
    int failures = 0;
    int dc;

    sa_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pe_en     (pe_en),
        .pe_clr    (pe_clr),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_row   (res_row)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] pack(logic b, logic d, logic e, logic en, logic clr,
                                         logic rv, logic [5:0] addr, logic resv,
                                         logic [1:0] row);
        return {b, d, e, en, clr, rv, resv, addr, row};
    endfunction

    function automatic logic [14:0] obs();
        return pack(busy, done, err, pe_en, pe_clr, rd_valid, rd_addr, res_valid, res_row);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One tile. stall_row: hold res_ready low 5 drain cycles at that row.
    // abort_c / rst_c: cycle after which abort / reset is applied (-1 = never).
    task automatic run_tile(input int k, input int stall_pct, input int stall_row,
                            input int abort_c, input int rst_c, output int done_c);
        int c, row, hold;
        logic [14:0] e;
        done_c = -1;
        row    = 0;
        hold   = 0;
        @(negedge clk);
        start = 1'b1;
        k_len = k[6:0];
        abort = 1'b0;
        @(posedge clk); #1;
        c = 1;
        while (1) begin
            if (c > 3000) begin
                chk("timeout", c, 0);
                @(negedge clk);
                start = 1'b0;
                return;
            end
            if (c == 1)                    e = pack(1, 0, 0, 0, 1, 0, 6'd0, 0, 2'd0);
            else if (c <= k + 1)           e = pack(1, 0, 0, 1, 0, 1, 6'(c - 2), 0, 2'd0);
            else if (c <= k + 1 + FLUSH)   e = pack(1, 0, 0, 1, 0, 0, 6'd0, 0, 2'd0);
            else if (row < ROWS)           e = pack(1, 0, 0, 0, 0, 0, 6'd0, 1, 2'(row));
            else                           e = pack(1, 1, 0, 0, 0, 0, 6'd0, 0, 2'd0);
            chk($sformatf("tile_k%0d_c%0d", k, c), obs(), e);
            chk("clr_en_excl", pe_clr & pe_en, 0);
            if (row >= ROWS) begin
                done_c = c;
                break;
            end
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            k_len = 7'($urandom_range(0, 127));
            if (c > k + 1 + FLUSH) begin
                if (row == stall_row && hold < 5) begin
                    res_ready = 1'b0;
                    hold++;
                end else begin
                    res_ready = ($urandom_range(0, 99) >= stall_pct);
                end
                if (res_ready) row++;
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
            if (c == abort_c) begin
                abort = 1'b1;
                @(posedge clk); #1;
                chk("abort_idle", obs(), 0);
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                return;
            end
            if (c == rst_c) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_async", obs(), 0);
                @(posedge clk); #1;
                chk("rst_held", obs(), 0);
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                @(posedge clk); #1;
                chk("rst_release_idle", obs(), 0);
                return;
            end
            c++;
            @(posedge clk); #1;
        end
        // A start during the DONE cycle must be ignored.
        @(negedge clk);
        start     = 1'b1;
        k_len     = 7'd5;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_done_idle", obs(), 0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic bad_start(input int k);
        @(negedge clk);
        start = 1'b1;
        k_len = k[6:0];
        @(posedge clk); #1;
        chk($sformatf("err_k%0d", k), obs(), pack(0, 0, 1, 0, 0, 0, 6'd0, 0, 2'd0));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("err_clear_k%0d", k), obs(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b1;
        k_len     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", obs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort while idle does nothing.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_idle", obs(), 0);
        @(negedge clk);
        abort = 1'b0;

        run_tile(8, 0, -1, -1, -1, dc);
        chk("latency_k8", dc, 2 + 8 + FLUSH + ROWS);

        bad_start(0);
        bad_start(65);
        bad_start(127);

        run_tile(1, 0, 2, -1, -1, dc);
        chk("latency_stall", dc, 2 + 1 + FLUSH + ROWS + 5);

        run_tile(8, 0, -1, 5, -1, dc);
        chk("abort_no_done", dc, -1);
        run_tile(4, 0, -1, -1, -1, dc);
        chk("latency_after_abort", dc, 2 + 4 + FLUSH + ROWS);

        run_tile(8, 0, -1, -1, 13, dc);
        chk("reset_no_done", dc, -1);
        run_tile(8, 0, -1, -1, -1, dc);
        chk("latency_after_reset", dc, 2 + 8 + FLUSH + ROWS);

        run_tile(K_MAX, 0, -1, -1, -1, dc);
        chk("latency_kmax", dc, 2 + K_MAX + FLUSH + ROWS);

        for (int i = 0; i < 6; i++) begin
            int kr;
            kr = $urandom_range(1, K_MAX);
            run_tile(kr, 30, -1, -1, -1, dc);
            chk($sformatf("rand_done_k%0d", kr), (dc >= 2 + kr + FLUSH + ROWS) ? 1 : 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_tile_ctrl.md
SA_TILE_CTRL -- requirements
Module: sa_tile_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, PE array rows and result rows drained.
REQ-002 SHALL have parameter COLS, default 4, PE array columns.
REQ-003 SHALL have parameter K_MAX, default 64, maximum reduction depth.
REQ-004 SHALL derive localparams KW=$clog2(K_MAX+1), AW=$clog2(K_MAX), RW=$clog2(ROWS), FLUSH=ROWS+COLS-1.
REQ-005 SHALL have clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have start  in  1  request one tile computation.
REQ-008 SHALL have k_len  in  KW  reduction depth, sampled with start.
REQ-009 SHALL have abort  in  1  cancel the current tile.
REQ-010 SHALL have busy  out  1  high in every state except IDLE.
REQ-011 SHALL have done  out  1  one-cycle pulse at tile completion.
REQ-012 SHALL have err  out  1  one-cycle pulse on a rejected start.
REQ-013 SHALL have pe_en  out  1  enable to all pe_mac instances.
REQ-014 SHALL have pe_clr  out  1  zero all PE accumulators.
REQ-015 SHALL have rd_valid  out  1  operand buffer read strobe.
REQ-016 SHALL have rd_addr  out  AW  operand buffer read index.
REQ-017 SHALL have res_valid  out  1  result row presented.
REQ-018 SHALL have res_ready  in  1  result consumer accepts the row.
REQ-019 SHALL have res_row  out  RW  index of the presented result row.

Function
REQ-020 SHALL implement states IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE; all outputs registered or decoded from state and counters only (Moore).
REQ-021 IDLE: start=1 with 1<=k_len<=K_MAX -> CLEAR, k_len latched; k_len==0 or k_len>K_MAX -> err=1 next cycle, remain IDLE.
REQ-022 CLEAR: exactly 1 cycle; pe_clr=1, pe_en=0, rd_valid=0; -> FEED.
REQ-023 FEED: exactly k_len cycles; pe_en=1, rd_valid=1, rd_addr=0,1,...,k_len-1 consecutively; -> FLUSH.
REQ-024 FLUSH: exactly FLUSH cycles; pe_en=1, rd_valid=0, rd_addr=0; -> DRAIN.
REQ-025 DRAIN: pe_en=0, res_valid=1, res_row starts at 0; row advances only when res_valid&&res_ready; accepting row ROWS-1 -> DONE.
REQ-026 DRAIN with res_ready=0: res_valid, res_row held stable, no timeout.
REQ-027 DONE: exactly 1 cycle; done=1, busy=1; -> IDLE.
REQ-028 start while busy SHALL be ignored (no err, no restart, latched k_len unchanged).
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle, no done pulse, all strobes low; abort in IDLE has no effect; abort wins over simultaneous start.
REQ-030 start in the cycle DONE is active SHALL be ignored; new start accepted from IDLE only.
REQ-031 Latency with res_ready=1: start sampled at cycle 0 -> done high at cycle 2+k_len+FLUSH+ROWS.
REQ-032 pe_clr and pe_en SHALL never be high in the same cycle.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE and busy=done=err=pe_en=pe_clr=rd_valid=res_valid=0, rd_addr=0, res_row=0, latched k_len=0.
REQ-034 Reset mid-tile SHALL abandon the tile without done; first start after release behaves as from power-up.

Verification
REQ-035 ROWS=COLS=4, start k_len=8, res_ready=1 -> CLEAR cycle 1, rd_addr 0..7 cycles 2-9, FLUSH cycles 10-16, res_row 0..3 cycles 17-20, done cycle 21.
REQ-036 start k_len=0, then k_len=65 -> err pulse each, busy stays 0, no pe_en/pe_clr.
REQ-037 k_len=1, res_ready low 5 cycles at row 2 -> res_row=2 held 5 cycles, done 5 cycles later than REQ-031.
REQ-038 abort during FEED at rd_addr=3 -> IDLE next cycle, no done; next start k_len=4 completes normally.
REQ-039 rst_n pulsed low mid-FLUSH -> all outputs 0 immediately, busy=0; start pulses while busy ignored.
REQ-040 Integration: 4x4 array of pe_mac, random 16-bit operands, k_len=K_MAX -> drained rows match reference matrix product (32-bit).
